aes_round_sequencer: RTL

- Controller that sequences the AES-128 encryption datapath through its round operations.
- On a start request it emits one-hot step enables in order: key expansion, SubBytes, ShiftRows, MixColumns, AddRoundKey. It also provides the round index, then signals completion.
- Sits between the host/SPI load logic and the round datapath. The datapath owns all data; this block owns only sequencing.

---
 rtl/aes_round_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - AES round-operation sequencer (one-hot step enables, round index)
module aes_round_sequencer #(
    parameter int NROUNDS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hold,
    output logic       busy,
    output logic       done,
    output logic [3:0] round,
    output logic       last_round,
    output logic       key_init,
    output logic       key_step,
    output logic       sub_en,
    output logic       shift_en,
    output logic       mix_en,
    output logic       ark_en
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        KEYEXP,
        SUB,
        SHIFT,
        MIX,
        ARK,
        DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(NROUNDS);

    state_t     state;
    state_t     state_next;
    logic [3:0] round_next;
    logic       stall;

    assign last_round = (round == LAST);

    // State and round registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            round <= 4'd0;
        end else begin
            state <= state_next;
            round <= round_next;
        end
    end

    // Next-state, round update and Moore step decode; hold freezes a busy run and masks its enables.
    always_comb begin
        state_next = state;
        round_next = round;
        busy       = 1'b0;
        done       = 1'b0;
        key_init   = 1'b0;
        key_step   = 1'b0;
        sub_en     = 1'b0;
        shift_en   = 1'b0;
        mix_en     = 1'b0;
        ark_en     = 1'b0;
        stall      = 1'b0;

        case (state)
            IDLE: begin
                round_next = 4'd0;
                if (start) begin
                    state_next = INIT;
                end
            end
            INIT: begin
                busy       = 1'b1;
                key_init   = 1'b1;
                ark_en     = 1'b1;
                state_next = KEYEXP;
                round_next = 4'd1;
            end
            KEYEXP: begin
                busy       = 1'b1;
                key_step   = 1'b1;
                state_next = SUB;
            end
            SUB: begin
                busy       = 1'b1;
                sub_en     = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                // The final round has no MixColumns.
                if (round == LAST) begin
                    state_next = ARK;
                end else begin
                    state_next = MIX;
                end
            end
            MIX: begin
                busy       = 1'b1;
                mix_en     = 1'b1;
                state_next = ARK;
            end
            ARK: begin
                busy   = 1'b1;
                ark_en = 1'b1;
                if (round == LAST) begin
                    state_next = DONE;
                end else begin
                    round_next = round + 4'd1;
                    state_next = KEYEXP;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
                round_next = 4'd0;
            end
            default: begin
                state_next = IDLE;
                round_next = 4'd0;
            end
        endcase

        // Hold only matters while busy; IDLE and DONE proceed regardless.
        stall = hold && busy;
        if (stall) begin
            state_next = state;
            round_next = round;
            key_init   = 1'b0;
            key_step   = 1'b0;
            sub_en     = 1'b0;
            shift_en   = 1'b0;
            mix_en     = 1'b0;
            ark_en     = 1'b0;
        end
    end

endmodule
